gb_cpu_regfile_mp: RTL and testbench

//  Parametrised, single-edge (posedge-only) register file for the CPU core.
//  - Holds NUM_REGS 8-bit registers, with 16-bit pair access on even/odd pairs.
//  - NUM_WP write ports with fixed priority, plus NUM_RP read ports with optional write bypass.
//  - A shadow bank supports interrupt context save/restore/swap.
//  - Collision detection and counting cover multi-port same-byte writes.
//  - Sits between the decoder/ALU/IDU/data-bus write sources and all datapath consumers.

---
 rtl/gb_cpu_regfile_mp_if.sv | 37 +++
 rtl/gb_cpu_regfile_mp.sv | 152 +++++++++++++++
 tb/tb_gb_cpu_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_cpu_regfile_mp_if.sv
// gb_cpu_regfile_mp_if: write/read/snapshot bus of the CPU register file.
// Latency: n/a (signal bundle only).
// Backpressure: none; the register file accepts every enabled access.
// master: write sources, read consumers and context control.
// slave: the register file itself.
interface gb_cpu_regfile_mp_if #(
  parameter int NUM_REGS = 16,
  parameter int NUM_WP   = 4,
  parameter int NUM_RP   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_WP-1:0]      wr_en;
  logic [NUM_WP-1:0]      wr_wide;
  logic [NUM_WP*AW-1:0]   wr_addr;
  logic [NUM_WP*16-1:0]   wr_data;
  logic [NUM_RP*AW-1:0]   rd_addr;
  logic [NUM_RP-1:0]      rd_wide;
  logic [NUM_RP*16-1:0]   rd_data;
  logic                   snap_save;
  logic                   snap_restore;
  logic                   snap_valid;
  logic                   restore_err;
  logic                   collision;
  logic [7:0]             collision_cnt;
  logic [NUM_REGS*8-1:0]  regs_flat;

  modport master (
    output wr_en, wr_wide, wr_addr, wr_data, rd_addr, rd_wide, snap_save, snap_restore,
    input  rd_data, snap_valid, restore_err, collision, collision_cnt, regs_flat
  );

  modport slave (
    input  wr_en, wr_wide, wr_addr, wr_data, rd_addr, rd_wide, snap_save, snap_restore,
    output rd_data, snap_valid, restore_err, collision, collision_cnt, regs_flat
  );
endinterface

// File: rtl/gb_cpu_regfile_mp.sv
// gb_cpu_regfile_mp: 8-bit register file with 16-bit pair access, per-byte prioritised
//   multi-port writes, optionally bypassed reads and a shadow bank for interrupt context.
// Latency: writes/snapshots land on the next posedge; reads are combinational.
// Backpressure: none; enabled writes are always accepted, byte losers are dropped and counted.
// Ports: clk, reset (synchronous, active-high); bus (slave modport): wr_* write ports,
//   rd_* read ports, snap_* context control, collision status, regs_flat live view.
module gb_cpu_regfile_mp #(
  parameter int                    NUM_REGS   = 16,
  parameter int                    NUM_WP     = 4,
  parameter int                    NUM_RP     = 2,
  parameter bit                    BYPASS     = 1'b1,
  parameter int                    FLAG_IDX   = 1,
  parameter logic [NUM_REGS*8-1:0] RESET_VALS = '0
) (
  input logic               clk,
  input logic               reset,
  gb_cpu_regfile_mp_if.slave bus
);
  localparam int          AW     = $clog2(NUM_REGS);
  localparam logic [AW:0] NREG_W = (AW+1)'(NUM_REGS);

  typedef logic [7:0] byte_t;

  byte_t         live_q   [NUM_REGS];
  byte_t         live_d   [NUM_REGS];
  byte_t         shadow_q [NUM_REGS];
  byte_t         shadow_d [NUM_REGS];
  logic          snap_valid_q, snap_valid_d;
  logic          restore_err_q, restore_err_d;
  logic          collision_q, collision_d;
  logic [7:0]    collision_cnt_q, collision_cnt_d;

  byte_t                win_dat [NUM_REGS];
  logic [NUM_REGS-1:0]  win_vld;
  logic [NUM_REGS-1:0]  multi_hit;
  byte_t                src     [NUM_REGS];
  logic                 restore_ok;
  logic [AW-1:0]        wa;
  logic [15:0]          wd;
  logic                 cov;
  logic [AW-1:0]        ra;

  assign restore_ok = bus.snap_restore & snap_valid_q;

  // The flag register's low nibble is hard-wired to zero on every path into storage.
  function automatic byte_t mask_flag(int idx, byte_t v);
    byte_t r;
    r = v;
    if (idx == FLAG_IDX) r[3:0] = 4'h0;
    return r;
  endfunction

  // Per-byte write resolution. Ports are scanned from highest priority down, so the
  // first port to cover a byte owns it and any later covering port marks a collision.
  // Indices past NUM_REGS never match a byte, which drops out-of-range writes.
  always_comb begin
    wa  = '0;
    wd  = '0;
    cov = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      win_vld[i]   = 1'b0;
      win_dat[i]   = '0;
      multi_hit[i] = 1'b0;
    end
    for (int p = 0; p < NUM_WP; p++) begin
      wa = bus.wr_addr[p*AW +: AW];
      wd = bus.wr_data[p*16 +: 16];
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.wr_wide[p]) cov = bus.wr_en[p] && ((wa >> 1) == (AW'(i) >> 1));
        else                cov = bus.wr_en[p] && (wa == AW'(i));
        if (cov) begin
          if (win_vld[i]) begin
            multi_hit[i] = 1'b1;
          end else begin
            win_vld[i] = 1'b1;
            // Even byte of a pair is the high half of the 16-bit word.
            win_dat[i] = mask_flag(i, (bus.wr_wide[p] && !i[0]) ? wd[15:8] : wd[7:0]);
          end
        end
      end
    end
  end

  // Next state. A valid restore takes the whole bank from the shadow and discards
  // port writes; the shadow always captures the pre-write live bank on save, which
  // makes save+restore an atomic swap.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        live_d[i]   = mask_flag(i, RESET_VALS[8*i +: 8]);
        shadow_d[i] = mask_flag(i, RESET_VALS[8*i +: 8]);
      end else begin
        live_d[i]   = restore_ok ? shadow_q[i] : (win_vld[i] ? win_dat[i] : live_q[i]);
        shadow_d[i] = bus.snap_save ? live_q[i] : shadow_q[i];
      end
    end
    if (reset) begin
      snap_valid_d    = 1'b0;
      restore_err_d   = 1'b0;
      collision_d     = 1'b0;
      collision_cnt_d = '0;
    end else begin
      snap_valid_d    = bus.snap_save ? 1'b1 : (restore_ok ? 1'b0 : snap_valid_q);
      restore_err_d   = bus.snap_restore & ~snap_valid_q;
      // Collisions count even when a restore throws the writes away.
      collision_d     = |multi_hit;
      collision_cnt_d = (collision_d && (collision_cnt_q != 8'hFF)) ? collision_cnt_q + 8'd1
                                                                    : collision_cnt_q;
    end
  end

  // Read source per byte: shadow during a valid restore, else the winning write, else live.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      src[i] = live_q[i];
      if (BYPASS) begin
        if (restore_ok)      src[i] = shadow_q[i];
        else if (win_vld[i]) src[i] = win_dat[i];
      end
    end
  end

  always_comb begin
    ra          = '0;
    bus.rd_data = '0;
    for (int r = 0; r < NUM_RP; r++) begin
      ra = bus.rd_addr[r*AW +: AW];
      if ({1'b0, ra} < NREG_W) begin
        if (bus.rd_wide[r]) bus.rd_data[r*16 +: 16] = {src[ra & ~AW'(1)], src[ra | AW'(1)]};
        else                bus.rd_data[r*16 +: 16] = {8'h00, src[ra]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) bus.regs_flat[8*i +: 8] = live_q[i];
  end

  assign bus.snap_valid    = snap_valid_q;
  assign bus.restore_err   = restore_err_q;
  assign bus.collision     = collision_q;
  assign bus.collision_cnt = collision_cnt_q;

  always_ff @(posedge clk) begin
    live_q          <= live_d;
    shadow_q        <= shadow_d;
    snap_valid_q    <= snap_valid_d;
    restore_err_q   <= restore_err_d;
    collision_q     <= collision_d;
    collision_cnt_q <= collision_cnt_d;
  end
endmodule

// File: tb/tb_gb_cpu_regfile_mp.sv
// tb_gb_cpu_regfile_mp: randomized and directed stimulus against a behavioural register
//   file model; expected responses are queued per cycle and checked by a monitor.
// Two instances share stimulus: one with read bypass, one without.
module tb_gb_cpu_regfile_mp;
  localparam logic [127:0] RV = 128'h3F3E3D3C_3B3A3938_37363534_3332B730;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gb_cpu_regfile_mp_if #(.NUM_REGS(16), .NUM_WP(4), .NUM_RP(2)) bus ();
  gb_cpu_regfile_mp_if #(.NUM_REGS(16), .NUM_WP(4), .NUM_RP(2)) bus_nb ();

  assign bus_nb.wr_en        = bus.wr_en;
  assign bus_nb.wr_wide      = bus.wr_wide;
  assign bus_nb.wr_addr      = bus.wr_addr;
  assign bus_nb.wr_data      = bus.wr_data;
  assign bus_nb.rd_addr      = bus.rd_addr;
  assign bus_nb.rd_wide      = bus.rd_wide;
  assign bus_nb.snap_save    = bus.snap_save;
  assign bus_nb.snap_restore = bus.snap_restore;

  gb_cpu_regfile_mp #(.NUM_REGS(16), .NUM_WP(4), .NUM_RP(2), .BYPASS(1'b1),
                      .FLAG_IDX(1), .RESET_VALS(RV)) dut (.clk(clk), .reset(reset), .bus(bus));
  gb_cpu_regfile_mp #(.NUM_REGS(16), .NUM_WP(4), .NUM_RP(2), .BYPASS(1'b0),
                      .FLAG_IDX(1), .RESET_VALS(RV)) dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

  typedef struct {
    logic [31:0]  rd_b;
    logic [31:0]  rd_n;
    bit           rd_chk;
    logic [127:0] regs;
    logic         sv;
    logic         err;
    logic         col;
    logic [7:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tot  = 0;
  int   n_pass = 0;

  // Stimulus for the current cycle
  logic [3:0]  s_en, s_wide;
  logic [3:0]  s_addr [4];
  logic [15:0] s_data [4];
  logic [3:0]  s_raddr [2];
  logic [1:0]  s_rwide;
  logic        s_save, s_restore, s_reset;

  // Reference model state
  logic [7:0] m_live [16];
  logic [7:0] m_shadow [16];
  logic       m_sv, m_err, m_col;
  int         m_cnt;
  bit         m_known = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] rv(int i);
    logic [127:0] img;
    logic [7:0]   v;
    img = RV;
    v   = img[8*i +: 8];
    if (i == 1) v[3:0] = 4'h0;
    return v;
  endfunction

  task automatic clear();
    s_en = '0; s_wide = '0; s_rwide = '0;
    s_save = 1'b0; s_restore = 1'b0; s_reset = 1'b0;
    for (int p = 0; p < 4; p++) begin s_addr[p] = '0; s_data[p] = '0; end
    for (int r = 0; r < 2; r++) s_raddr[r] = '0;
  endtask

  // Apply one cycle of stimulus, predict its reads and the state after the edge.
  task automatic step();
    logic [7:0] wv [16];
    int         own [16];
    logic [7:0] vb [16];
    logic [7:0] old [16];
    exp_t       e;
    logic       rok, collided;
    int         t, a;
    logic [7:0] b;

    reset            = s_reset;
    bus.wr_en        = s_en;
    bus.wr_wide      = s_wide;
    bus.rd_wide      = s_rwide;
    bus.snap_save    = s_save;
    bus.snap_restore = s_restore;
    for (int p = 0; p < 4; p++) begin
      bus.wr_addr[p*4 +: 4]   = s_addr[p];
      bus.wr_data[p*16 +: 16] = s_data[p];
    end
    for (int r = 0; r < 2; r++) bus.rd_addr[r*4 +: 4] = s_raddr[r];

    // Which bytes each port targets; first (highest-priority) claimant keeps its byte.
    for (int i = 0; i < 16; i++) begin own[i] = 0; wv[i] = '0; end
    for (int p = 0; p < 4; p++) begin
      if (s_en[p]) begin
        for (int k = 0; k < (s_wide[p] ? 2 : 1); k++) begin
          if (s_wide[p]) begin
            t = (int'(s_addr[p]) / 2) * 2 + k;
            b = (k == 0) ? s_data[p][15:8] : s_data[p][7:0];
          end else begin
            t = int'(s_addr[p]);
            b = s_data[p][7:0];
          end
          if (t == 1) b[3:0] = 4'h0;
          if (own[t] == 0) wv[t] = b;
          own[t]++;
        end
      end
    end

    rok = s_restore && m_sv;
    for (int i = 0; i < 16; i++) vb[i] = rok ? m_shadow[i] : ((own[i] > 0) ? wv[i] : m_live[i]);
    for (int r = 0; r < 2; r++) begin
      a = int'(s_raddr[r]);
      if (s_rwide[r]) begin
        e.rd_b[r*16 +: 16] = {vb[a - a % 2], vb[a - a % 2 + 1]};
        e.rd_n[r*16 +: 16] = {m_live[a - a % 2], m_live[a - a % 2 + 1]};
      end else begin
        e.rd_b[r*16 +: 16] = {8'h00, vb[a]};
        e.rd_n[r*16 +: 16] = {8'h00, m_live[a]};
      end
    end
    e.rd_chk = m_known;

    if (s_reset) begin
      for (int i = 0; i < 16; i++) begin m_live[i] = rv(i); m_shadow[i] = rv(i); end
      m_sv = 1'b0; m_err = 1'b0; m_col = 1'b0; m_cnt = 0;
      m_known = 1'b1;
    end else begin
      collided = 1'b0;
      for (int i = 0; i < 16; i++) if (own[i] >= 2) collided = 1'b1;
      m_err = s_restore && !m_sv;
      m_col = collided;
      if (collided && m_cnt < 255) m_cnt++;
      for (int i = 0; i < 16; i++) old[i] = m_live[i];
      for (int i = 0; i < 16; i++) m_live[i] = rok ? m_shadow[i] : ((own[i] > 0) ? wv[i] : old[i]);
      if (s_save) for (int i = 0; i < 16; i++) m_shadow[i] = old[i];
      m_sv = s_save ? 1'b1 : (rok ? 1'b0 : m_sv);
    end

    for (int i = 0; i < 16; i++) e.regs[8*i +: 8] = m_live[i];
    e.sv  = m_sv;
    e.err = m_err;
    e.col = m_col;
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: reads checked mid-cycle, registered state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb[0];
        if (e.rd_chk) begin
          chk("rd_data_bypass", 128'(bus.rd_data), 128'(e.rd_b));
          chk("rd_data_nobypass", 128'(bus_nb.rd_data), 128'(e.rd_n));
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("regs_flat", bus.regs_flat, e.regs);
        chk("regs_flat_nobypass", bus_nb.regs_flat, e.regs);
        chk("snap_valid", 128'(bus.snap_valid), 128'(e.sv));
        chk("restore_err", 128'(bus.restore_err), 128'(e.err));
        chk("collision", 128'(bus.collision), 128'(e.col));
        chk("collision_cnt", 128'(bus.collision_cnt), 128'(e.cnt));
      end
    end
  end

  initial begin
    clear();
    s_reset = 1'b1;
    reset   = 1'b1;
    @(posedge clk);
    #2;
    step(); step();
    clear(); step();

    // Wide port0 on pair 2/3 beats narrow port2 on reg3
    s_en = 4'b0101; s_wide = 4'b0001;
    s_addr[0] = 4'd2; s_data[0] = 16'h1234;
    s_addr[2] = 4'd3; s_data[2] = 16'h00AA;
    step();
    clear(); step();

    // Same-cycle read of a byte being written
    s_en = 4'b0010; s_addr[1] = 4'd5; s_data[1] = 16'h005A;
    s_raddr[0] = 4'd5; s_raddr[1] = 4'd4; s_rwide = 2'b10;
    step();
    clear(); s_raddr[0] = 4'd5; step();

    // Wide write over the flag pair, odd address selects the same pair
    s_en = 4'b0001; s_wide = 4'b0001; s_addr[0] = 4'd1; s_data[0] = 16'hFFFF;
    s_raddr[0] = 4'd0; s_rwide = 2'b01;
    step();

    // Save / write / restore with a concurrent write that must be dropped
    clear(); s_en = 4'b0001; s_addr[0] = 4'd0; s_data[0] = 16'h0011; step();
    clear(); s_save = 1'b1; step();
    clear(); s_en = 4'b0001; s_addr[0] = 4'd0; s_data[0] = 16'h0022; step();
    clear(); s_restore = 1'b1; s_en = 4'b1000; s_addr[3] = 4'd0; s_data[3] = 16'h0033; step();
    clear(); step();

    // Swap, then restore to expose the swapped shadow
    clear(); s_save = 1'b1; step();
    clear(); s_en = 4'b0001; s_addr[0] = 4'd0; s_data[0] = 16'h0022; step();
    clear(); s_save = 1'b1; s_restore = 1'b1; step();
    clear(); s_restore = 1'b1; step();

    // Restore without a saved context: error pulse, writes still land
    clear(); s_restore = 1'b1; s_en = 4'b0100; s_addr[2] = 4'd7; s_data[2] = 16'h0077; step();
    clear(); s_save = 1'b1; s_restore = 1'b1; step();

    // Collision during a discarding restore is still counted
    clear(); s_restore = 1'b1; s_en = 4'b0011; s_addr[0] = 4'd9; s_addr[1] = 4'd9; step();

    // Counter saturation
    repeat (300) begin
      clear(); s_en = 4'b0011; s_addr[0] = 4'd4; s_addr[1] = 4'd4;
      s_data[0] = 16'($urandom); s_data[1] = 16'($urandom);
      step();
    end
    clear(); step();

    // Reset overrides concurrent writes and save
    clear(); s_reset = 1'b1; s_en = 4'hF; s_save = 1'b1; s_data[0] = 16'hDEAD; step();
    clear(); step();

    repeat (2000) begin
      clear();
      s_en = 4'($urandom); s_wide = 4'($urandom); s_rwide = 2'($urandom);
      for (int p = 0; p < 4; p++) begin s_addr[p] = 4'($urandom); s_data[p] = 16'($urandom); end
      for (int r = 0; r < 2; r++) s_raddr[r] = 4'($urandom);
      s_save    = ($urandom_range(0, 7) == 0);
      s_restore = ($urandom_range(0, 7) == 0);
      s_reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    clear();

    repeat (4) @(posedge clk);
    chk("scoreboard_drain", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
